// File: rtl/video_pkg.sv
// Shared video constants and types for the framebuffer producer/consumer.
// Test pattern colours, default geometry and the writer state encoding.
package video_pkg;
  localparam int HDISP_DEF = 800;
  localparam int VDISP_DEF = 480;
  localparam int BURST_DEF = 64;
  localparam int GRID_DEF  = 16;

  localparam logic [31:0] WHITE = 32'h00FF_FFFF;
  localparam logic [31:0] BLACK = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    YIELD
  } mire_state_t;
endpackage

// File: rtl/pixel_scan_counter.sv
// Raster x/y scan counter with line/frame wrap and last-pixel flag.
// Shared by the framebuffer writer and the video reader.
module pixel_scan_counter #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int XW    = $clog2(HDISP),
  parameter int YW    = $clog2(VDISP)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);
  logic x_end;
  logic y_end;

  assign x_end = (x == XW'(HDISP - 1));
  assign y_end = (y == YW'(VDISP - 1));
  assign last  = x_end && y_end;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end
endmodule

// File: rtl/wshb_mire_writer.sv
// Wishbone classic master filling the framebuffer with a grid pattern.
// Drops cyc for one cycle every BURST acked writes to let other masters in.
module wshb_mire_writer
  import video_pkg::*;
#(
  parameter int HDISP = HDISP_DEF,
  parameter int VDISP = VDISP_DEF,
  parameter int BURST = BURST_DEF,
  parameter int GRID  = GRID_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  output logic [3:0]  sel,
  output logic [2:0]  cti,
  output logic [1:0]  bte,
  input  logic        ack,
  input  logic        err,
  input  logic        rty,
  output logic        frame_done
);
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int BW = $clog2(BURST) + 1;

  mire_state_t   state;
  logic [BW-1:0] burst_cnt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          last;
  logic          advance;
  logic [31:0]   pix;
  logic          on_grid;

  assign we  = 1'b1;
  assign sel = 4'hF;
  assign cti = 3'b000;
  assign bte = 2'b00;

  assign advance = stb && ack;

  pixel_scan_counter #(
    .HDISP(HDISP),
    .VDISP(VDISP),
    .XW   (XW),
    .YW   (YW)
  ) u_scan (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .advance(advance),
    .x      (x),
    .y      (y),
    .last   (last)
  );

  assign pix     = 32'(y) * 32'(HDISP) + 32'(x);
  assign on_grid = ((32'(x) & 32'(GRID - 1)) == 32'd0)
                || ((32'(y) & 32'(GRID - 1)) == 32'd0);

  assign adr        = stb ? (pix << 2) : 32'd0;
  assign dat_ms     = stb ? (on_grid ? WHITE : BLACK) : BLACK;
  assign frame_done = advance && last;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      cyc       <= 1'b0;
      stb       <= 1'b0;
      burst_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= WRITE;
            cyc   <= 1'b1;
            stb   <= 1'b1;
          end
        end
        WRITE: begin
          if (ack) begin
            if (burst_cnt == BW'(BURST - 1)) begin
              state     <= YIELD;
              cyc       <= 1'b0;
              stb       <= 1'b0;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + BW'(1);
              if (!enable) begin
                state <= IDLE;
                cyc   <= 1'b0;
                stb   <= 1'b0;
              end
            end
          end else if (err || rty) begin
            // counters hold, so the same pixel is reissued
            cyc <= 1'b1;
            stb <= 1'b1;
          end
        end
        YIELD: begin
          state <= enable ? WRITE : IDLE;
          cyc   <= enable;
          stb   <= enable;
        end
        default: begin
          state <= IDLE;
          cyc   <= 1'b0;
          stb   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wshb_mire_writer.sv
// Directed bench: full-size writer (bursts, pattern, err/rty, enable drop)
// plus a 32x4 writer for frame wrap and frame_done.
module tb_wshb_mire_writer;
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst_a, en_a, auto_a, err_a, rty_a;
  logic        cyc_a, stb_a, we_a, ack_a, fd_a;
  logic [31:0] adr_a, dat_a;
  logic [3:0]  sel_a;
  logic [2:0]  cti_a;
  logic [1:0]  bte_a;

  logic        rst_b, en_b, err_b, rty_b;
  logic        cyc_b, stb_b, we_b, ack_b, fd_b;
  logic [31:0] adr_b, dat_b;
  logic [3:0]  sel_b;
  logic [2:0]  cti_b;
  logic [1:0]  bte_b;

  assign ack_a = auto_a & stb_a;
  assign ack_b = stb_b;

  wshb_mire_writer dut_a (
    .sys_clk(sys_clk), .sys_rst(rst_a), .enable(en_a),
    .cyc(cyc_a), .stb(stb_a), .we(we_a), .adr(adr_a),
    .dat_ms(dat_a), .sel(sel_a), .cti(cti_a), .bte(bte_a),
    .ack(ack_a), .err(err_a), .rty(rty_a), .frame_done(fd_a)
  );

  wshb_mire_writer #(.HDISP(32), .VDISP(4)) dut_b (
    .sys_clk(sys_clk), .sys_rst(rst_b), .enable(en_b),
    .cyc(cyc_b), .stb(stb_b), .we(we_b), .adr(adr_b),
    .dat_ms(dat_b), .sel(sel_b), .cti(cti_b), .bte(bte_b),
    .ack(ack_b), .err(err_b), .rty(rty_b), .frame_done(fd_b)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_adr(input logic [31:0] target, input int budget);
    int n = 0;
    while (!(stb_a === 1'b1 && adr_a === target) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk("reach_adr", adr_a, target);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    rst_a = 1'b1; en_a = 1'b0; auto_a = 1'b0; err_a = 1'b0; rty_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; err_b = 1'b0; rty_b = 1'b0;
    repeat (3) @(negedge sys_clk);

    chk("rst_cyc", {31'b0, cyc_a}, 32'd0);
    chk("rst_stb", {31'b0, stb_a}, 32'd0);
    chk("rst_adr", adr_a, 32'd0);
    chk("rst_dat", dat_a, 32'd0);
    chk("rst_fd", {31'b0, fd_a}, 32'd0);
    chk("rst_we", {31'b0, we_a}, 32'd1);
    chk("rst_sel", {28'b0, sel_a}, 32'hF);
    chk("rst_cti", {29'b0, cti_a}, 32'd0);
    chk("rst_bte", {30'b0, bte_a}, 32'd0);

    // zero-wait burst of 64, one yield cycle, resume at 0x100
    rst_a = 1'b0; en_a = 1'b1; auto_a = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge sys_clk);
      chk("burst_cyc", {31'b0, cyc_a}, 32'd1);
      chk("burst_adr", adr_a, 32'(4 * i));
      if (i == 0) chk("px00_dat", dat_a, 32'h00FF_FFFF);
    end
    @(negedge sys_clk);
    chk("yield_cyc", {31'b0, cyc_a}, 32'd0);
    chk("yield_stb", {31'b0, stb_a}, 32'd0);
    @(negedge sys_clk);
    chk("resume_cyc", {31'b0, cyc_a}, 32'd1);
    chk("resume_adr", adr_a, 32'h100);

    wait_adr(32'(4 * 800), 30000);
    chk("px_0_1", dat_a, 32'h00FF_FFFF);
    wait_adr(32'(4 * 801), 30000);
    chk("px_1_1", dat_a, 32'h0000_0000);
    wait_adr(32'(4 * (5 * 800 + 16)), 30000);
    chk("px_16_5", dat_a, 32'h00FF_FFFF);
    wait_adr(32'(4 * (17 * 800 + 17)), 30000);
    chk("px_17_17", dat_a, 32'h0000_0000);
    wait_adr(32'(4 * (32 * 800 + 3)), 30000);
    chk("px_3_32", dat_a, 32'h00FF_FFFF);

    // asynchronous reset in the middle of a write
    #2;
    rst_a = 1'b1;
    #1;
    chk("arst_cyc", {31'b0, cyc_a}, 32'd0);
    chk("arst_stb", {31'b0, stb_a}, 32'd0);
    chk("arst_adr", adr_a, 32'd0);
    chk("arst_dat", dat_a, 32'd0);
    en_a = 1'b0;
    @(negedge sys_clk);
    rst_a = 1'b0;
    @(negedge sys_clk);
    chk("off_stb", {31'b0, stb_a}, 32'd0);

    // err then rty on 0x40: same pixel reissued
    en_a = 1'b1;
    wait_adr(32'h40, 200);
    auto_a = 1'b0; err_a = 1'b1;
    @(negedge sys_clk);
    err_a = 1'b0;
    chk("err_stb", {31'b0, stb_a}, 32'd1);
    chk("err_adr", adr_a, 32'h40);
    chk("err_dat", dat_a, 32'h00FF_FFFF);
    rty_a = 1'b1;
    @(negedge sys_clk);
    rty_a = 1'b0;
    chk("rty_adr", adr_a, 32'h40);
    auto_a = 1'b1;
    @(negedge sys_clk);
    chk("after_err", adr_a, 32'h44);
    err_a = 1'b1;
    @(negedge sys_clk);
    err_a = 1'b0;
    chk("ack_wins", adr_a, 32'h48);

    // enable drops while stb pending; ack arrives on the 5th cycle
    wait_adr(32'h80, 200);
    auto_a = 1'b0; en_a = 1'b0;
    repeat (4) begin
      @(negedge sys_clk);
      chk("hold_stb", {31'b0, stb_a}, 32'd1);
      chk("hold_adr", adr_a, 32'h80);
    end
    auto_a = 1'b1;
    @(negedge sys_clk);
    chk("stop_stb", {31'b0, stb_a}, 32'd0);
    chk("stop_cyc", {31'b0, cyc_a}, 32'd0);
    @(negedge sys_clk);
    chk("idle_stb", {31'b0, stb_a}, 32'd0);
    en_a = 1'b1;
    @(negedge sys_clk);
    chk("reen_stb", {31'b0, stb_a}, 32'd1);
    chk("reen_adr", adr_a, 32'h84);

    // 32x4 frame: two frames, frame_done on pixel 127 of each
    rst_b = 1'b0; en_b = 1'b1;
    n = 0; pulses = 0;
    for (int c = 0; c < 600 && n < 256; c++) begin
      @(negedge sys_clk);
      if (stb_b) begin
        chk("fr_adr", adr_b, 32'(4 * (n % 128)));
        chk("fr_done", {31'b0, fd_b}, (n % 128 == 127) ? 32'd1 : 32'd0);
        if (fd_b) pulses++;
        n++;
      end else begin
        chk("fr_gap_done", {31'b0, fd_b}, 32'd0);
      end
    end
    chk("fr_acks", 32'(n), 32'd256);
    chk("fr_pulses", 32'(pulses), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
